instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode stage (ID + control_unit).
//  - Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
//  - Buffers returned words with their PCs in a small fetch queue.
//  - Presents the queue head to decode with a valid/ready handshake.
//  - On a redirect (branch/jump from EX), flushes the queue and squashes any stale in-flight response.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h00000000  fetch PC after reset
//  FQ_DEPTH  2             fetch-queue entries (power of 2, >=2)
// PORTS
//  clk             in   1     clock; all state updates on posedge
//  rst             in   1     asynchronous, active-high reset
//  imem_req        out  1     read request; held high until imem_ack
//  imem_addr       out  XLEN  word address; stable while imem_req=1
//  imem_ack        in   1     imem_rdata valid this cycle; completes the request
//  imem_rdata      in   32    instruction word
//  redirect_valid  in   1     one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   XLEN  new PC; bits [1:0] ignored (forced to 00)
//  if_valid        out  1     queue head valid toward ID
//  if_instr        out  32    head instruction; 32'h00000013 (NOP) when if_valid=0
//  if_pc           out  XLEN  head PC; 0 when if_valid=0
//  id_ready        in   1     ID accepts head when if_valid & id_ready
// BEHAVIOUR
//  Reset (async, immediate):
//  - fetch_pc = RESET_PC; queue empty; req_pending = 0; drop = 0.
//  - Outputs: imem_req = 0, imem_addr = RESET_PC, if_valid = 0, if_instr = NOP, if_pc = 0.
//  Issue:
//  - occ = count + (req_pending & ~drop).
//  - A new request is issued when both hold:
//    - (~req_pending | imem_ack) & ~redirect_valid;
//    - occ after this cycle's pop/ack is < FQ_DEPTH.
//  - On issue: req_pending <= 1, imem_addr <= fetch_pc, fetch_pc <= fetch_pc + 4.
//  - Back-to-back issue on the ack cycle is allowed, giving 1 instr/cycle with a 1-cycle memory.
//  Response:
//  - On imem_ack with drop = 0: push {imem_addr, imem_rdata}; if_valid rises the next cycle.
//  - On imem_ack with drop = 1: discard the data; drop <= 0.
//  - The queue never overflows, because a slot is reserved at issue.
//  Output:
//  - if_valid = (count != 0). Head fields are driven combinationally from registered queue storage.
//  - Pop on if_valid & id_ready. A push and a pop in the same cycle leaves count unchanged.
//  - id_ready = 0 holds the head stable indefinitely.
//  Redirect (takes priority over everything else that cycle):
//  - Queue flushed (count <= 0; a same-cycle pop is irrelevant).
//  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
//  - If req_pending and no imem_ack this cycle: drop <= 1. The request stays asserted with the
//    unchanged address until acked, then its data is discarded.
//  - If imem_ack arrives in the same cycle: the data is discarded, and no issue happens that cycle.
//  - The first request at the new PC is issued on the next eligible cycle after the redirect.
//  - A second redirect while drop = 1 keeps drop = 1 and updates fetch_pc only.
//  Arithmetic:
//  - PC increment is modulo 2^XLEN: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag.
//  Timing:
//  - Minimum latency from request to if_valid = memory latency + 1 cycle.
//  - No combinational path from id_ready to imem_req.
// STRUCTURE
//  Shared package/header (riscv_defs):
//  - XLEN, RESET_PC default, INSTR_NOP = 32'h00000013, OPCODE_* constants (also used by control_unit).
//  Sub-module fetch_fifo (inst u_fq):
//  - Parameterised synchronous FIFO of {pc, instr}.
//  - Ports: push, pop, flush, full, empty, count, head outputs.
//  - flush has priority over push and pop.
//  Top level: issue/drop control and the PC register only.
// TESTING
//  1. Reset, 1-cycle ack memory, id_ready = 1 -> PCs 0,4,8,12 appear one per cycle after fill;
//     if_instr matches imem contents.
//  2. id_ready = 0 for 5 cycles after 2 fetches -> count = 2, imem_req = 0, head PC = 0 held;
//     release -> 0,4,8 in order.
//  3. Redirect to 32'h00000103 while a request for PC 8 is pending, ack 2 cycles later ->
//     PC 8 word dropped, next if_pc = 32'h00000100, queue emptied.
//  4. Redirect on the same cycle as imem_ack -> acked word never reaches if_valid;
//     following fetch at the redirect target.
//  5. RESET_PC = 32'hFFFFFFF8 -> if_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
//  6. rst asserted mid-request with the queue full -> same-cycle imem_req = 0, if_valid = 0;
//     after release, first imem_addr = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: widths, reset defaults, NOP encoding, RV32 opcodes.
package instr_fetch_pkg;

   localparam int          XLEN         = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Fetch queue: small synchronous FIFO of {pc, instr}; flush beats push and pop.
module instr_fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int AW    = XLEN,
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [AW-1:0] push_pc,
   input  logic [31:0]   push_instr,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic [AW-1:0] head_pc,
   output logic [31:0]   head_instr
);

   logic [AW-1:0] r_pc_mem    [DEPTH];
   logic [31:0]   r_instr_mem [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign w_pop_ok  = pop & ~empty;
   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign w_push_ok = push & (~full | w_pop_ok);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until counted, so no reset.
   always_ff @(posedge clk) begin
      if (w_push_ok & ~flush) begin
         r_pc_mem[r_wr_ptr]    <= push_pc;
         r_instr_mem[r_wr_ptr] <= push_instr;
      end
   end

   assign count      = r_count;
   assign head_pc    = r_pc_mem[r_rd_ptr];
   assign head_instr = r_instr_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, imem req/ack issue control, stale-response drop, queue to ID.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int              XLEN     = instr_fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              FQ_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            id_ready
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;
   localparam int OW = CW + 1;

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_addr;
   logic            r_req_pending;
   logic            r_drop;

   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic [XLEN-1:0] w_head_pc;
   logic [31:0]     w_head_instr;
   logic            w_pop;
   logic            w_push;
   logic            w_in_flight;
   logic [OW-1:0]   w_occ_next;
   logic            w_issue;
   logic [XLEN-1:0] w_redirect_aligned;

   assign w_redirect_aligned = redirect_pc & ~XLEN'(3);
   assign w_pop  = ~w_empty & id_ready;
   // A redirect squashes the word arriving this cycle as well as anything queued.
   assign w_push = imem_ack & r_req_pending & ~r_drop & ~redirect_valid & (~w_full | w_pop);
   // A request still outstanding after this cycle already owns a queue slot.
   assign w_in_flight = r_req_pending & ~imem_ack & ~r_drop;
   assign w_occ_next  = OW'(w_count) + OW'(w_push) + OW'(w_in_flight) - OW'(w_pop);
   assign w_issue     = (~r_req_pending | imem_ack) & ~redirect_valid
                      & (w_occ_next < OW'(FQ_DEPTH));

   // Fetch PC, request handshake and stale-response drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_addr        <= RESET_PC;
         r_req_pending <= 1'b0;
         r_drop        <= 1'b0;
      end else begin
         if (redirect_valid)
            r_fetch_pc <= w_redirect_aligned;
         else if (w_issue)
            r_fetch_pc <= r_fetch_pc + XLEN'(4);

         if (w_issue) begin
            r_req_pending <= 1'b1;
            r_addr        <= r_fetch_pc;
         end else if (imem_ack) begin
            r_req_pending <= 1'b0;
         end

         if (redirect_valid & r_req_pending & ~imem_ack)
            r_drop <= 1'b1;
         else if (imem_ack)
            r_drop <= 1'b0;
      end
   end

   instr_fetch_fifo #(
      .AW    (XLEN),
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push),
      .pop        (w_pop),
      .flush      (redirect_valid),
      .push_pc    (r_addr),
      .push_instr (imem_rdata),
      .full       (w_full),
      .empty      (w_empty),
      .count      (w_count),
      .head_pc    (w_head_pc),
      .head_instr (w_head_instr)
   );

   assign imem_req  = r_req_pending;
   assign imem_addr = r_addr;
   assign if_valid  = ~w_empty;
   assign if_instr  = w_empty ? INSTR_NOP : w_head_instr;
   assign if_pc     = w_empty ? '0 : w_head_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand sequences for redirects/reset.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        imem_req, imem_ack, redirect_valid, if_valid, id_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc;
   logic        mem_auto, ack_man;

   logic        req5, ack5, valid5;
   logic [31:0] addr5, rdata5, instr5, pc5;

   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (~a) ^ 32'h1234_5678;
   endfunction

   // Zero-wait memory: ack in the same cycle as the request (1-cycle access).
   assign imem_ack   = mem_auto ? imem_req : ack_man;
   assign imem_rdata = mem_word(imem_addr);
   assign ack5       = req5;
   assign rdata5     = mem_word(addr5);

   instr_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut5 (
      .clk(clk), .rst(rst),
      .imem_req(req5), .imem_addr(addr5), .imem_ack(ack5), .imem_rdata(rdata5),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .if_valid(valid5), .if_instr(instr5), .if_pc(pc5), .id_ready(1'b1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ack_man        = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        do_rst;
      logic        rdy;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [1:0]  exp_cnt;
   } vec_t;

   vec_t vecs[17];

   initial begin
      logic found;
      mem_auto       = 1'b1;
      ack_man        = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // do_rst rdy valid pc req addr cnt
      // Streaming at one instruction per cycle.
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  2'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  2'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b1, 32'h4,  2'd1};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h8,  2'd1};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'hC,  2'd1};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h10, 2'd1};
      // Backpressure: queue fills to 2, requests stop, head held, then drains in order.
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  2'd0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  2'd0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h4,  2'd1};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h4,  2'd2};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h4,  2'd2};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h4,  2'd2};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h4,  2'd2};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h4,  2'd2};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h4,  2'd2};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h8,  2'd1};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'hC,  2'd1};

      @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].do_rst) reset_dut();
         id_ready = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_valid ? vecs[i].exp_pc : 32'h0);
         chk($sformatf("vec%0d_instr", i), if_instr,
             vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0000_0013);
         chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req || vecs[i].do_rst)
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_cnt", i), 32'(dut.u_fq.count), 32'(vecs[i].exp_cnt));
         step();
      end

      // Redirect while the PC 8 request is outstanding; ack two cycles later.
      mem_auto = 1'b0;
      id_ready = 1'b1;
      reset_dut();
      step();
      ack_man = 1'b1;
      step();
      step();
      ack_man = 1'b0;
      #1;
      chk("t3_pc4", if_pc, 32'h4);
      chk("t3_addr8", imem_addr, 32'h8);
      step();
      chk("t3_pend_req", 32'(imem_req), 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("t3_hold_addr", imem_addr, 32'h8);
      chk("t3_empty", 32'(if_valid), 32'h0);
      step();
      ack_man = 1'b1;
      #1;
      chk("t3_drop_valid", 32'(if_valid), 32'h0);
      step();
      chk("t3_new_addr", imem_addr, 32'h0000_0100);
      chk("t3_no_stale", 32'(if_valid), 32'h0);
      step();
      ack_man = 1'b0;
      #1;
      chk("t3_valid", 32'(if_valid), 32'h1);
      chk("t3_pc", if_pc, 32'h0000_0100);
      chk("t3_instr", if_instr, mem_word(32'h0000_0100));
      chk("t3_cnt", 32'(dut.u_fq.count), 32'h1);

      // Redirect in the same cycle as the ack.
      reset_dut();
      step();
      chk("t4_req", 32'(imem_req), 32'h1);
      ack_man        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step();
      ack_man        = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("t4_no_issue", 32'(imem_req), 32'h0);
      chk("t4_no_valid", 32'(if_valid), 32'h0);
      step();
      chk("t4_req_tgt", 32'(imem_req), 32'h1);
      chk("t4_addr_tgt", imem_addr, 32'h0000_0200);
      chk("t4_still_empty", 32'(if_valid), 32'h0);
      ack_man = 1'b1;
      step();
      ack_man = 1'b0;
      #1;
      chk("t4_valid", 32'(if_valid), 32'h1);
      chk("t4_pc", if_pc, 32'h0000_0200);

      // PC wrap from the top of the address space (second instance).
      reset_dut();
      #1;
      chk("t5_rst_addr", addr5, 32'hFFFF_FFF8);
      step();
      step();
      chk("t5_pc0", pc5, 32'hFFFF_FFF8);
      step();
      chk("t5_pc1", pc5, 32'hFFFF_FFFC);
      step();
      chk("t5_pc2", pc5, 32'h0000_0000);
      chk("t5_instr2", instr5, mem_word(32'h0));

      // Asynchronous reset with a word queued and a request outstanding.
      id_ready = 1'b0;
      reset_dut();
      step();
      ack_man = 1'b1;
      step();
      ack_man = 1'b0;
      #1;
      chk("t6_pre_req", 32'(imem_req), 32'h1);
      chk("t6_pre_valid", 32'(if_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_req", 32'(imem_req), 32'h0);
      chk("t6_rst_valid", 32'(if_valid), 32'h0);
      chk("t6_rst_instr", if_instr, 32'h0000_0013);
      @(negedge clk);
      rst      = 1'b0;
      mem_auto = 1'b1;
      id_ready = 1'b1;
      found    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (imem_req) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("t6_req_seen", 32'(found), 32'h1);
      chk("t6_first_addr", imem_addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
